instqueue: RTL and testbench

Instruction queue between instruction fetch (IF) and the decoder. It buffers fetched 32-bit instructions with their PCs in program order and presents the oldest entry to the decoder. It is flushed by the decoder (JAL redirect) or by the ROB (mispredict/rollback). It also back-pressures IF with an almost-full flag.

---
 rtl/instqueue_pkg.sv | 14 +
 rtl/instqueue_circ_buffer_ram.sv | 25 ++
 rtl/instqueue.sv | 83 ++++++++
 tb/tb_instqueue.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/instqueue_pkg.sv
// Shared widths and the queue entry layout for the instruction queue.
package instqueue_pkg;

  localparam int IDWidth      = 32;
  localparam int AddressWidth = 32;

  typedef struct packed {
    logic [IDWidth-1:0]      inst;
    logic [AddressWidth-1:0] pc;
  } iq_entry_t;

  localparam int EntryWidth = $bits(iq_entry_t);

endpackage

// File: rtl/instqueue_circ_buffer_ram.sv
// DEPTH x WIDTH register array: synchronous write, asynchronous read, no reset on storage.
module circ_buffer_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [DEPTH-1:0][WIDTH-1:0] mem;

  for (genvar i = 0; i < DEPTH; i++) begin : g_row
    always_ff @(posedge clk_in) begin
      if (we && waddr == AW'(i)) mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instqueue.sv
// In-order instruction queue between IF and the decoder, flushable by decoder or ROB.
module instqueue
  import instqueue_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    if_instqueue_en_in,
  input  logic [IDWidth-1:0]      if_instqueue_inst_in,
  input  logic [AddressWidth-1:0] if_instqueue_pc_in,
  output logic                    instqueue_if_full_out,
  output logic                    instqueue_decoder_en_out,
  output logic [IDWidth-1:0]      instqueue_decoder_inst_out,
  output logic [AddressWidth-1:0] instqueue_decoder_pc_out,
  input  logic                    decoder_instqueue_rst_in,
  input  logic                    rob_instqueue_rst_in,
  input  logic                    dispatcher_instqueue_stall_in
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL  = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_AFULL = (PW+1)'(DEPTH - AFULL_MARGIN);

  logic [PW-1:0] head, tail;
  logic [PW:0]   count, count_nxt;
  logic          flush, push, pop;
  iq_entry_t     wr_entry, rd_entry;

  assign flush = decoder_instqueue_rst_in | rob_instqueue_rst_in;
  assign pop   = rdy_in & (count != '0) & ~dispatcher_instqueue_stall_in & ~flush;
  // A push into a full queue is dropped here rather than overwriting the head.
  assign push  = rdy_in & if_instqueue_en_in & ~flush & (count != CNT_FULL);

  always_comb begin
    count_nxt = count;
    if (flush)
      count_nxt = '0;
    else
      count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      head                  <= '0;
      tail                  <= '0;
      count                 <= '0;
      instqueue_if_full_out <= 1'b0;
    end else if (rdy_in) begin
      if (flush) begin
        head <= '0;
        tail <= '0;
      end else begin
        if (push) tail <= tail + 1'b1;
        if (pop)  head <= head + 1'b1;
      end
      count                 <= count_nxt;
      instqueue_if_full_out <= (count_nxt >= CNT_AFULL);
    end
  end

  assign wr_entry.inst = if_instqueue_inst_in;
  assign wr_entry.pc   = if_instqueue_pc_in;

  circ_buffer_ram #(
    .DEPTH (DEPTH),
    .WIDTH (EntryWidth)
  ) u_ram (
    .clk_in (clk_in),
    .we     (push),
    .waddr  (tail),
    .wdata  (wr_entry),
    .raddr  (head),
    .rdata  (rd_entry)
  );

  assign instqueue_decoder_en_out   = pop;
  assign instqueue_decoder_inst_out = rd_entry.inst;
  assign instqueue_decoder_pc_out   = rd_entry.pc;

endmodule

// File: tb/tb_instqueue.sv
// Directed stimulus with a scoreboard; a negedge monitor checks every consumed head entry.
module tb_instqueue;
  import instqueue_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        if_en;
  logic [31:0] if_inst, if_pc;
  logic        full_out, dec_en;
  logic [31:0] dec_inst, dec_pc;
  logic        dec_rst, rob_rst, stall;

  int n_chk  = 0;
  int n_fail = 0;
  logic [63:0] sb[$];

  instqueue #(.DEPTH(16), .AFULL_MARGIN(2)) dut (
    .clk_in                        (clk_in),
    .rst_in                        (rst_in),
    .rdy_in                        (rdy_in),
    .if_instqueue_en_in            (if_en),
    .if_instqueue_inst_in          (if_inst),
    .if_instqueue_pc_in            (if_pc),
    .instqueue_if_full_out         (full_out),
    .instqueue_decoder_en_out      (dec_en),
    .instqueue_decoder_inst_out    (dec_inst),
    .instqueue_decoder_pc_out      (dec_pc),
    .decoder_instqueue_rst_in      (dec_rst),
    .rob_instqueue_rst_in          (rob_rst),
    .dispatcher_instqueue_stall_in (stall)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed head must be the oldest expected entry.
  always @(negedge clk_in) begin
    if (dec_en === 1'b1) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pop: got pc %h expected no pop", dec_pc);
      end else begin
        logic [63:0] exp;
        exp = sb.pop_front();
        check("pop_order", {dec_inst, dec_pc}, exp);
      end
    end
  end

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic drive_push(input logic [31:0] inst, input logic [31:0] pc, input bit expect_accept);
    if_en   = 1'b1;
    if_inst = inst;
    if_pc   = pc;
    if (expect_accept) sb.push_back({inst, pc});
  endtask

  task automatic flush_test(input bit use_rob);
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive_push(32'hC000 + i, 32'h500 + 4*i, 1'b1);
      step();
    end
    drive_push(32'hC0FF, 32'h99, 1'b0);
    stall = 1'b0;
    if (use_rob) rob_rst = 1'b1; else dec_rst = 1'b1;
    sb.delete();
    #3 check(use_rob ? "t5_rob_flush_en" : "t5_dec_flush_en", 64'(dec_en), 64'd0);
    step();
    if_en = 1'b0; dec_rst = 1'b0; rob_rst = 1'b0;
    #3 check("t5_empty_after", {63'd0, dec_en}, 64'd0);
    check("t5_full_after", {63'd0, full_out}, 64'd0);
    step();
    #3 check("t5_push_lost", {63'd0, dec_en}, 64'd0);
    step();
    drive_push(32'hC100, 32'h200, 1'b1);
    step();
    if_en = 1'b0;
    #3 check("t5_restart", {31'd0, dec_en, dec_pc}, {31'd0, 1'b1, 32'h200});
    step();
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1; if_en = 1'b0; if_inst = '0; if_pc = '0;
    dec_rst = 1'b0; rob_rst = 1'b0; stall = 1'b0;
    #12;
    check("reset_en", {63'd0, dec_en}, 64'd0);
    check("reset_full", {63'd0, full_out}, 64'd0);
    step();
    rst_in = 1'b0;
    step();

    // 1: single push, one-cycle latency
    drive_push(32'h0000_0013, 32'h0, 1'b1);
    step();
    if_en = 1'b0;
    #3 check("t1_head", {31'd0, dec_en, dec_inst}, {31'd0, 1'b1, 32'h0000_0013});
    step();
    #3 check("t1_empty", {63'd0, dec_en}, 64'd0);
    step();

    // 2: fill under stall, overflow dropped, drain in order
    stall = 1'b1;
    for (int i = 0; i < 16; i++) begin
      drive_push(32'h1000 + i, 32'(4*i), 1'b1);
      step();
      if (i == 12) #3 check("t2_full_at13", {63'd0, full_out}, 64'd0);
      if (i == 13) #3 check("t2_full_at14", {63'd0, full_out}, 64'd1);
    end
    drive_push(32'h1FFF, 32'h40, 1'b0);
    step();
    if_en = 1'b0;
    #3 check("t2_full_held", {62'd0, full_out, dec_en}, {62'd0, 1'b1, 1'b0});
    stall = 1'b0;
    repeat (16) step();
    #3 check("t2_drained", {62'd0, full_out, dec_en}, 64'd0);
    check("t2_sb_empty", 64'(sb.size()), 64'd0);
    step();

    // 3: streaming push/pop across several pointer wraps
    for (int i = 0; i < 40; i++) begin
      drive_push(32'hA000 + i, 32'h100 + 4*i, 1'b1);
      step();
    end
    if_en = 1'b0;
    step();
    #3 check("t3_empty", {63'd0, dec_en}, 64'd0);
    check("t3_sb_empty", 64'(sb.size()), 64'd0);
    step();

    // 4: push and pop together with one entry
    stall = 1'b1;
    drive_push(32'hB0, 32'h10, 1'b1);
    step();
    drive_push(32'hB1, 32'h14, 1'b1);
    stall = 1'b0;
    #3 check("t4_pop_head", {31'd0, dec_en, dec_pc}, {31'd0, 1'b1, 32'h10});
    step();
    if_en = 1'b0;
    stall = 1'b1;
    #3 check("t4_next_head", {31'd0, dec_en, dec_pc}, {31'd0, 1'b0, 32'h14});
    step();
    #3 check("t4_stall_hold", {31'd0, dec_en, dec_pc}, {31'd0, 1'b0, 32'h14});
    stall = 1'b0;
    step();
    #3 check("t4_empty", {63'd0, dec_en}, 64'd0);
    step();

    // 5: flush from decoder, then from ROB
    flush_test(1'b0);
    flush_test(1'b1);

    // 6: freeze with rdy_in low, then async reset mid-cycle
    stall = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive_push(32'hD000 + i, 32'h300 + 4*i, 1'b1);
      step();
    end
    rdy_in = 1'b0;
    drive_push(32'hDFFF, 32'h3FC, 1'b0);
    stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) dec_rst = 1'b1;
      #3 check("t6_frozen_en", {63'd0, dec_en}, 64'd0);
      step();
      check("t6_frozen_full", {63'd0, full_out}, 64'd0);
    end
    rdy_in = 1'b1; if_en = 1'b0; dec_rst = 1'b0;
    #3 check("t6_unfreeze_head", {31'd0, dec_en, dec_pc}, {31'd0, 1'b1, 32'h300});
    step();
    stall = 1'b1;
    drive_push(32'hE000, 32'h400, 1'b1);
    step();
    drive_push(32'hE001, 32'h404, 1'b1);
    step();
    if_en = 1'b0;
    check("t6_full_set", {63'd0, full_out}, 64'd1);
    stall = 1'b0;
    #1 check("t6_pre_reset_head", {31'd0, dec_en, dec_pc}, {31'd0, 1'b1, 32'h304});
    #1 rst_in = 1'b1;
    sb.delete();
    #1 check("t6_async_reset", {62'd0, full_out, dec_en}, 64'd0);
    step();
    step();
    rst_in = 1'b0;
    step();
    #3 check("t6_after_reset", {62'd0, full_out, dec_en}, 64'd0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
